// File: rtl/mem_subword_lsu_pkg.sv
// Shared definitions for the sub-word load/store unit: access size codes,
// FSM state type and the alignment rule applied at request acceptance.
package mem_subword_lsu_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } lsu_state_t;

    // True when the request can never be issued: illegal size or misaligned lane.
    function automatic logic req_bad(input logic [1:0] size, input logic [1:0] lane);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = lane[0];
            SZ_WORD: bad = (lane != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/mem_subword_lsu_lane.sv
// Lane logic shared by both directions: extracts and extends a load lane,
// and builds the read-modify-write word for a sub-word store.
module subword_lane
    import mem_subword_lsu_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  lane,
    input  logic        is_unsigned,
    input  logic [31:0] word_in,
    input  logic [31:0] store_data,
    output logic [31:0] load_ext,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel    = word_in[7:0];
        half_sel    = lane[1] ? word_in[31:16] : word_in[15:0];
        load_ext    = word_in;
        merged_word = store_data;

        case (lane)
            2'd1:    byte_sel = word_in[15:8];
            2'd2:    byte_sel = word_in[23:16];
            2'd3:    byte_sel = word_in[31:24];
            default: byte_sel = word_in[7:0];
        endcase

        case (size)
            SZ_BYTE: begin
                load_ext    = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
                merged_word = word_in;
                case (lane)
                    2'd1:    merged_word[15:8]  = store_data[7:0];
                    2'd2:    merged_word[23:16] = store_data[7:0];
                    2'd3:    merged_word[31:24] = store_data[7:0];
                    default: merged_word[7:0]   = store_data[7:0];
                endcase
            end
            SZ_HALF: begin
                load_ext    = {{16{~is_unsigned & half_sel[15]}}, half_sel};
                merged_word = word_in;
                if (lane[1])
                    merged_word[31:16] = store_data[15:0];
                else
                    merged_word[15:0]  = store_data[15:0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_subword_lsu.sv
// Byte-addressed load/store front end for a single-port word memory:
// word-aligned accesses, read-modify-write for sub-word stores, load extension.
module mem_subword_lsu
    import mem_subword_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic        mem_re,
    output logic        mem_we,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    lsu_state_t  state, state_next;
    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        err_q;
    logic [CW-1:0] tcnt;

    logic        accept_bad;
    logic        timeout_hit;
    logic [31:0] load_ext;
    logic [31:0] merged_word;

    assign accept_bad  = req_bad(req_size, req_addr[1:0]);
    assign timeout_hit = (TIMEOUT != 0) && !mem_ack && (tcnt == CW'(TIMEOUT - 1));

    assign req_ready  = (state == IDLE);
    assign resp_valid = (state == RESP);
    assign resp_err   = (state == RESP) && err_q;
    assign mem_re     = (state == READ);
    assign mem_we     = (state == WRITE);

    subword_lane u_lane (
        .size        (size_q),
        .lane        (lane_q),
        .is_unsigned (uns_q),
        .word_in     (mem_rdata),
        .store_data  (wdata_q),
        .load_ext    (load_ext),
        .merged_word (merged_word)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (accept_bad)
                        state_next = RESP;
                    else if (req_we && req_size == SZ_WORD)
                        state_next = WRITE;
                    else
                        state_next = READ;
                end
            end
            READ: begin
                if (mem_ack)
                    state_next = we_q ? WRITE : RESP;
                else if (timeout_hit)
                    state_next = RESP;
            end
            WRITE: begin
                if (mem_ack || timeout_hit)
                    state_next = RESP;
            end
            default: state_next = IDLE;
        endcase
    end

    // resp_rdata is cleared at acceptance, so stores, errors and timeouts report zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            we_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            lane_q     <= 2'b00;
            wdata_q    <= '0;
            err_q      <= 1'b0;
            tcnt       <= '0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            resp_rdata <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q       <= req_we;
                        size_q     <= req_size;
                        uns_q      <= req_unsigned;
                        lane_q     <= req_addr[1:0];
                        wdata_q    <= req_wdata;
                        err_q      <= accept_bad;
                        tcnt       <= '0;
                        mem_addr   <= {req_addr[31:2], 2'b00};
                        resp_rdata <= '0;
                        if (!accept_bad && req_we && req_size == SZ_WORD)
                            mem_wdata <= req_wdata;
                    end
                end
                READ, WRITE: begin
                    if (mem_ack) begin
                        tcnt <= '0;
                        if (state == READ) begin
                            if (we_q)
                                mem_wdata <= merged_word;
                            else
                                resp_rdata <= load_ext;
                        end
                    end else if (timeout_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        tcnt <= tcnt + CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_subword_lsu.sv
// Self-checking bench: behavioural word memory with programmable ack delay
// and a lane-arithmetic reference model for loads, stores and latency.
module tb_mem_subword_lsu;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int checks = 0;
    int failures = 0;

    int ack_delay = 0;
    bit no_ack = 1'b0;
    bit noise = 1'b0;
    int wait_cnt = 0;
    int re_cycles = 0, we_cycles = 0, rd_count = 0, wr_count = 0, both_strobes = 0;
    logic [31:0] mem_model [int];
    logic [31:0] exp_mem [int];

    always #5 clk = ~clk;

    mem_subword_lsu #(.TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_we       (req_we),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .mem_addr     (mem_addr),
        .mem_re       (mem_re),
        .mem_we       (mem_we),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack)
    );

    // Memory responder: decides ack and read data half a cycle before the DUT samples.
    always @(negedge clk) begin
        if (mem_re && mem_we) both_strobes++;
        if (mem_re) re_cycles++;
        if (mem_we) we_cycles++;
        if ((mem_re || mem_we) && !no_ack) begin
            if (wait_cnt >= ack_delay) begin
                mem_ack   = 1'b1;
                mem_rdata = mem_model.exists(int'(mem_addr >> 2)) ? mem_model[int'(mem_addr >> 2)] : 32'h0;
                wait_cnt  = 0;
            end else begin
                mem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            mem_ack   = (noise && !(mem_re || mem_we)) ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
            wait_cnt  = 0;
        end
    end

    always @(posedge clk) begin
        if (mem_re && mem_ack) rd_count++;
        if (mem_we && mem_ack) begin
            mem_model[int'(mem_addr >> 2)] = mem_wdata;
            wr_count++;
        end
    end

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] lo,
                                             input logic [1:0] sz, input bit uns);
        logic [31:0] v;
        if (sz == 2'd0) begin
            v = (w >> (8 * lo)) & 32'hFF;
            if (!uns && v[7]) v = v | 32'hFFFF_FF00;
        end else if (sz == 2'd1) begin
            v = (w >> (16 * lo[1])) & 32'hFFFF;
            if (!uns && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] old, input logic [1:0] lo,
                                              input logic [1:0] sz, input logic [31:0] wd);
        logic [31:0] mask;
        int sh;
        if (sz == 2'd2) return wd;
        sh   = (sz == 2'd0) ? 8 * lo : 16 * lo[1];
        mask = ((sz == 2'd0) ? 32'hFF : 32'hFFFF) << sh;
        return (old & ~mask) | ((wd << sh) & mask);
    endfunction

    function automatic bit ref_bad(input logic [1:0] sz, input logic [1:0] lo);
        return (sz == 2'd3) || (sz == 2'd1 && lo[0]) || (sz == 2'd2 && lo != 2'd0);
    endfunction

    task automatic preload(input logic [31:0] addr, input logic [31:0] w);
        mem_model[int'(addr >> 2)] = w;
        exp_mem[int'(addr >> 2)]   = w;
    endtask

    // Drives one request, scrambles the request bus after acceptance, and
    // measures cycles from acceptance to resp_valid.
    task automatic run_txn(input bit we, input logic [1:0] size, input bit uns,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output logic [31:0] rdata, output logic err, output int lat,
                           output bit hung, output bit bad_pulse);
        @(negedge clk);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_addr     = $urandom;
        req_wdata    = $urandom;
        lat  = 1;
        hung = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (resp_valid) begin
                hung = 1'b0;
                break;
            end
            lat++;
        end
        rdata     = resp_rdata;
        err       = resp_err;
        bad_pulse = req_ready;
        @(negedge clk);
        bad_pulse = bad_pulse | resp_valid;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({req_ready, resp_valid, resp_err, mem_re, mem_we} !== 5'b10000) begin
            failures++;
            $display("[TB] FAIL reset_ctrl got=%b exp=10000", {req_ready, resp_valid, resp_err, mem_re, mem_we});
        end
        checks++;
        if (resp_rdata !== 32'h0 || mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin
            failures++;
            $display("[TB] FAIL reset_data got=%h/%h/%h exp=0/0/0", resp_rdata, mem_addr, mem_wdata);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_idle got=%b%b exp=10", req_ready, resp_valid);
        end
    endtask

    task automatic test_load_half();
        logic [31:0] rd; logic er; int lat; bit hg, bp;
        logic [31:0] addrs [3] = '{32'h102, 32'h100, 32'h102};
        bit          unss  [3] = '{1'b0, 1'b0, 1'b1};
        logic [31:0] exps  [3] = '{32'hFFFF_8001, 32'h0000_7FFF, 32'h0000_8001};
        preload(32'h100, 32'h8001_7FFF);
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b0, 2'd1, unss[i], addrs[i], 32'h0, rd, er, lat, hg, bp);
            checks++;
            if (hg || er !== 1'b0 || rd !== exps[i] || lat != 2 || bp) begin
                failures++;
                $display("[TB] FAIL load_half_%0d got=%h err=%b lat=%0d exp=%h err=0 lat=2", i, rd, er, lat, exps[i]);
            end
        end
    endtask

    task automatic test_store_byte();
        logic [31:0] rd; logic er; int lat; bit hg, bp;
        int r0, w0;
        preload(32'h200, 32'h1122_3344);
        r0 = rd_count; w0 = wr_count;
        run_txn(1'b1, 2'd0, 1'b0, 32'h201, 32'hFFFF_FFAB, rd, er, lat, hg, bp);
        checks++;
        if (hg || lat != 3 || er !== 1'b0 || rd !== 32'h0 || bp) begin
            failures++;
            $display("[TB] FAIL sb_resp got lat=%0d err=%b rd=%h exp lat=3 err=0 rd=0", lat, er, rd);
        end
        checks++;
        if (mem_model[int'(32'h200 >> 2)] !== 32'h1122_AB44) begin
            failures++;
            $display("[TB] FAIL sb_mem got=%h exp=1122ab44", mem_model[int'(32'h200 >> 2)]);
        end
        checks++;
        if (rd_count - r0 != 1 || wr_count - w0 != 1) begin
            failures++;
            $display("[TB] FAIL sb_accesses got rd=%0d wr=%0d exp rd=1 wr=1", rd_count - r0, wr_count - w0);
        end
    endtask

    task automatic test_store_half_word();
        logic [31:0] rd; logic er; int lat; bit hg, bp;
        int r0, w0;
        preload(32'h300, 32'hDEAD_BEEF);
        run_txn(1'b1, 2'd1, 1'b0, 32'h302, 32'h5555_1234, rd, er, lat, hg, bp);
        checks++;
        if (hg || lat != 3 || mem_model[int'(32'h300 >> 2)] !== 32'h1234_BEEF) begin
            failures++;
            $display("[TB] FAIL sh_upper got=%h lat=%0d exp=1234beef lat=3", mem_model[int'(32'h300 >> 2)], lat);
        end
        r0 = re_cycles; w0 = wr_count;
        run_txn(1'b1, 2'd2, 1'b0, 32'h300, 32'hCAFE_BABE, rd, er, lat, hg, bp);
        checks++;
        if (hg || lat != 2 || re_cycles != r0 || wr_count - w0 != 1 ||
            mem_model[int'(32'h300 >> 2)] !== 32'hCAFE_BABE) begin
            failures++;
            $display("[TB] FAIL sw_word got=%h lat=%0d re=%0d wr=%0d exp=cafebabe lat=2 re=0 wr=1",
                     mem_model[int'(32'h300 >> 2)], lat, re_cycles - r0, wr_count - w0);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat; bit hg, bp;
        int r0, w0;
        logic [31:0] addrs [3] = '{32'h401, 32'h402, 32'h400};
        logic [1:0]  sizes [3] = '{2'd1, 2'd2, 2'd3};
        for (int i = 0; i < 3; i++) begin
            r0 = re_cycles; w0 = we_cycles;
            run_txn(i[0], sizes[i], 1'b0, addrs[i], 32'hFFFF_FFFF, rd, er, lat, hg, bp);
            checks++;
            if (hg || er !== 1'b1 || lat != 1 || rd !== 32'h0 || re_cycles != r0 || we_cycles != w0 || bp) begin
                failures++;
                $display("[TB] FAIL error_%0d got err=%b lat=%0d rd=%h strobes=%0d exp err=1 lat=1 rd=0 strobes=0",
                         i, er, lat, rd, (re_cycles - r0) + (we_cycles - w0));
            end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] rd; logic er; int lat; bit hg, bp;
        preload(32'h700, 32'h89AB_CDEF);
        ack_delay = 3;
        run_txn(1'b0, 2'd0, 1'b0, 32'h703, 32'h0, rd, er, lat, hg, bp);
        ack_delay = 0;
        checks++;
        if (hg || lat != 5 || er !== 1'b0 || rd !== 32'hFFFF_FF89) begin
            failures++;
            $display("[TB] FAIL wait_load got lat=%0d rd=%h err=%b exp lat=5 rd=ffffff89 err=0", lat, rd, er);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] rd; logic er; int lat; bit hg, bp;
        int r0, we0, w0;
        preload(32'h600, 32'h0102_0304);
        no_ack = 1'b1;
        r0 = re_cycles; we0 = we_cycles; w0 = wr_count;
        run_txn(1'b1, 2'd0, 1'b0, 32'h602, 32'h77, rd, er, lat, hg, bp);
        repeat (3) @(negedge clk);
        no_ack = 1'b0;
        checks++;
        if (hg || er !== 1'b1 || rd !== 32'h0 || lat != TMO + 1) begin
            failures++;
            $display("[TB] FAIL timeout_resp got err=%b rd=%h lat=%0d exp err=1 rd=0 lat=%0d", er, rd, lat, TMO + 1);
        end
        checks++;
        if (re_cycles - r0 != TMO || we_cycles != we0 || wr_count != w0) begin
            failures++;
            $display("[TB] FAIL timeout_strobes got re=%0d we=%0d exp re=%0d we=0", re_cycles - r0, we_cycles - we0, TMO);
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, exp_rd, addr, wd, old; logic er; int lat, exp_lat, d, r0, w0; bit hg, bp, bad, we, uns;
        logic [1:0] sz;
        int errs;
        for (int k = 0; k < 4; k++) preload(32'h500 + 4 * k, $urandom);
        noise = 1'b1;
        for (int n = 0; n < 60; n++) begin
            errs = 0;
            we   = 1'($urandom);
            sz   = 2'($urandom_range(0, 3));
            uns  = 1'($urandom);
            addr = 32'h500 + 32'($urandom_range(0, 15));
            wd   = $urandom;
            d    = $urandom_range(0, 2);
            ack_delay = d;
            old  = exp_mem[int'(addr >> 2)];
            bad  = ref_bad(sz, addr[1:0]);
            r0 = rd_count; w0 = wr_count;
            run_txn(we, sz, uns, addr, wd, rd, er, lat, hg, bp);
            exp_rd  = (bad || we) ? 32'h0 : ref_load(old, addr[1:0], sz, uns);
            exp_lat = bad ? 1 : (!we || sz == 2'd2) ? 2 + d : 3 + 2 * d;
            if (we && !bad) exp_mem[int'(addr >> 2)] = ref_store(old, addr[1:0], sz, wd);
            checks++;
            if (hg || er !== bad || rd !== exp_rd || lat != exp_lat || bp) begin
                failures++;
                $display("[TB] FAIL rand_%0d_resp we=%b sz=%0d a=%h got rd=%h err=%b lat=%0d exp rd=%h err=%b lat=%0d",
                         n, we, sz, addr, rd, er, lat, exp_rd, bad, exp_lat);
            end
            checks++;
            if (mem_model[int'(addr >> 2)] !== exp_mem[int'(addr >> 2)]) begin
                failures++;
                $display("[TB] FAIL rand_%0d_mem a=%h got=%h exp=%h", n, addr, mem_model[int'(addr >> 2)], exp_mem[int'(addr >> 2)]);
            end
            checks++;
            if (rd_count - r0 != ((bad || (we && sz == 2'd2)) ? 0 : 1) || wr_count - w0 != ((we && !bad) ? 1 : 0)) begin
                failures++;
                $display("[TB] FAIL rand_%0d_accesses got rd=%0d wr=%0d", n, rd_count - r0, wr_count - w0);
            end
        end
        noise = 1'b0;
        ack_delay = 0;
        checks++;
        if (both_strobes != 0) begin
            failures++;
            $display("[TB] FAIL strobe_exclusive got=%0d exp=0", both_strobes);
        end
    endtask

    task automatic test_reset_mid_write();
        int w0;
        bit saw_resp;
        preload(32'h800, 32'h0);
        no_ack = 1'b1;
        w0 = wr_count;
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_addr = 32'h800; req_wdata = 32'h1357_9BDF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (mem_we !== 1'b1) begin
            failures++;
            $display("[TB] FAIL rst_pre_write got mem_we=%b exp=1", mem_we);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || resp_valid !== 1'b0) begin
            failures++;
            $display("[TB] FAIL rst_async_drop got we=%b re=%b rv=%b exp 0/0/0", mem_we, mem_re, resp_valid);
        end
        saw_resp = 1'b0;
        repeat (2) begin @(negedge clk); saw_resp |= resp_valid; end
        rst = 1'b0;
        no_ack = 1'b0;
        repeat (4) begin @(negedge clk); saw_resp |= resp_valid; end
        checks++;
        if (saw_resp || req_ready !== 1'b1 || wr_count != w0) begin
            failures++;
            $display("[TB] FAIL rst_recover got resp=%b ready=%b writes=%0d exp resp=0 ready=1 writes=0",
                     saw_resp, req_ready, wr_count - w0);
        end
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog got=timeout exp=finish");
        $fatal(1, "[TB] simulation watchdog expired");
    end

    initial begin
        test_reset();
        test_load_half();
        test_store_byte();
        test_store_half_word();
        test_errors();
        test_wait_states();
        test_timeout();
        test_random();
        test_reset_mid_write();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_subword_lsu.md
Name: mem_subword_lsu

Overview:
- Memory-side load/store unit: the other end of the ALU's half-word lane handling.
- Takes byte-addressed load/store requests (byte/half/word) from the pipeline and turns them into word-aligned accesses on a single-port word memory.
- Performs read-modify-write for sub-word stores, and lane extraction plus sign/zero extension for loads.
- Sits between the MEM stage and data memory/bus; stalls the pipeline through a valid/ready handshake.

Parameters:
- TIMEOUT, 255, max cycles to wait for mem_ack per memory phase; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_we  in  1  1=store, 0=load.
- req_size  in  2  00=byte, 01=half, 10=word, 11=illegal.
- req_unsigned  in  1  loads: 1=zero-extend, 0=sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  load result, extended; 0 for stores and errors.
- resp_err  out  1  qualifies resp_valid: misaligned, illegal size or timeout.
- mem_addr  out  32  {req_addr[31:2],2'b00}.
- mem_re  out  1  word read strobe, held until ack.
- mem_we  out  1  word write strobe, held until ack.
- mem_wdata  out  32  full word to write.
- mem_rdata  in  32  read word, valid with mem_ack.
- mem_ack  in  1  completes the current mem_re/mem_we phase.

Behaviour:
- Reset (async): state=IDLE. req_ready=1; resp_valid, resp_err, mem_re, mem_we = 0; resp_rdata, mem_addr, mem_wdata = 0; timeout counter = 0.
- Byte order is little-endian. Lane is addr[1:0]. Half at addr[1]=1 occupies [31:16]; byte lane n occupies [8n+7:8n].
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. Violation or size=11 -> error.
- Handshake:
  - Accept on req_valid & req_ready; request fields are latched at acceptance.
  - req_ready is 1 only in IDLE and never in the cycle resp_valid is high.
- States:
  - IDLE: on accept, error -> RESP with err=1 and no memory access; word store -> WRITE (mem_wdata=req_wdata); otherwise -> READ.
  - READ: mem_re=1. On mem_ack capture mem_rdata. Load -> RESP. Sub-word store -> WRITE, with mem_wdata = captured word with only the target lane(s) replaced by req_wdata low bits (registered merge).
  - WRITE: mem_we=1 until mem_ack -> RESP.
  - RESP: resp_valid=1 for exactly one cycle -> IDLE.
- Load result:
  - byte: lane sign/zero-extended to 32.
  - half: selected half extended.
  - word: raw word.
- Latency with mem_ack in the first strobe cycle, accept at cycle T:
  - load: resp_valid at T+2.
  - word store: resp_valid at T+2.
  - sub-word store: read T+1, write T+2, resp_valid at T+3.
  - error: resp_valid at T+1.
  - Each additional wait cycle on mem_ack adds one cycle.
- Timeout:
  - Counter clears on entering READ/WRITE and increments each cycle without ack.
  - If count reaches TIMEOUT: drop the strobe, go to RESP with err=1, resp_rdata=0; no write is issued afterward.
- mem_ack outside READ/WRITE is ignored.
- mem_addr is stable from the first strobe cycle until ack.
- mem_re and mem_we are never both 1.
- Reset mid-operation: the transaction is abandoned, strobes drop immediately (async), and no response is produced.

Decomposition:
- Shared package:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state localparams IDLE/READ/WRITE/RESP.
- One combinational sub-module, subword_lane (ports: size, lane, unsigned, word_in, store_data; outputs: load_ext, merged_word), shared by load extraction and store merge.

Test Plan:
- Load half signed: mem word 0x8001_7FFF, addr 0x102 -> resp_rdata=0xFFFF_8001; addr 0x100 -> 0x0000_7FFF; lhu at 0x102 -> 0x0000_8001.
- Store byte RMW: mem word 0x1122_3344, sb 0xAB at addr 0x201 -> one read then one write of 0x1122_AB44; resp_valid at T+3.
- Store half upper: mem word 0xDEAD_BEEF, sh 0x1234 at 0x302 -> write 0x1234_BEEF. Word store 0xCAFEBABE at 0x300 -> no mem_re, write only.
- Misaligned/illegal: half at 0x401, word at 0x402, size=11 -> resp_err=1 at T+1, mem_re/mem_we never asserted.
- Wait states and timeout: ack delayed 3 cycles -> resp_valid at T+5 for a load. With TIMEOUT=4 and no ack -> resp_err=1 after 4 strobe cycles, no write follows.
- Async reset asserted during WRITE -> mem_we drops without a clock edge, no resp_valid, req_ready=1 after reset release.
